// File: rtl/gpr_ir_mar_datapath.sv
// FPG8 register-side datapath: 8 x 16-bit GPR file, instruction register with field decode,
// and memory address register on the shared tri-state bus. Optional macro: GPR_R0_ZERO_EN.
module gpr_ir_mar_datapath #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned NUM_REGS = 8
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire logic [WIDTH-1:0] DATA,
  input  logic             GPR_in,
  input  logic             GPR_out,
  input  logic [2:0]       GPR_select,
  input  logic             IR_in,
  input  logic             MAR_in,
  input  logic             r_en,
  input  logic             w_en,
  output logic [WIDTH-1:0] REG_OUT_0,
  output logic [WIDTH-1:0] REG_OUT_1,
  output logic [WIDTH-1:0] REG_OUT_2,
  output logic [WIDTH-1:0] REG_OUT_3,
  output logic [WIDTH-1:0] REG_OUT_4,
  output logic [WIDTH-1:0] REG_OUT_5,
  output logic [WIDTH-1:0] REG_OUT_6,
  output logic [WIDTH-1:0] REG_OUT_7,
  output logic [WIDTH-1:0] REG_OUT_IR,
  output logic [3:0]       opcode_out,
  output logic [2:0]       rd_out_1,
  output logic [2:0]       rd_out_2,
  output logic             S,
  output logic [1:0]       shift,
  output logic [2:0]       rs_1,
  output logic [2:0]       rs_2,
  output logic [WIDTH-1:0] REG_OUT_MAR
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    SEL_RD1 = 3'b000,
    SEL_RD2 = 3'b001,
    SEL_RS1 = 3'b010,
    SEL_RS2 = 3'b011,
    SEL_PC  = 3'b100,
    SEL_SP  = 3'b101,
    SEL_R0A = 3'b110,
    SEL_R0B = 3'b111
  } gpr_sel_e;

  logic [WIDTH-1:0] gpr [NUM_REGS];
  logic [WIDTH-1:0] ir_q;
  logic [WIDTH-1:0] mar_q;
  logic [IDX_W-1:0] sel_idx;
  logic [WIDTH-1:0] sel_val;
  logic             write_ok;

  // Operand index comes from the IR currently held, so an IR load on the same
  // edge as a GPR write still targets the register named by the old IR.
  always_comb begin
    sel_idx = '0;
    case (gpr_sel_e'(GPR_select))
      SEL_RD1: sel_idx = ir_q[11:9];
      SEL_RD2: sel_idx = ir_q[8:6];
      SEL_RS1: sel_idx = ir_q[5:3];
      SEL_RS2: sel_idx = ir_q[2:0];
      SEL_PC:  sel_idx = IDX_W'(7);
      SEL_SP:  sel_idx = IDX_W'(6);
      default: sel_idx = '0;
    endcase
  end

`ifdef GPR_R0_ZERO_EN
  assign sel_val   = (sel_idx == '0) ? '0 : gpr[sel_idx];
  assign write_ok  = (sel_idx != '0);
  assign REG_OUT_0 = '0;
`else
  assign sel_val   = gpr[sel_idx];
  assign write_ok  = 1'b1;
  assign REG_OUT_0 = gpr[0];
`endif

  assign DATA = GPR_out ? sel_val : 'z;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        gpr[i] <= '0;
      end
      ir_q  <= '0;
      mar_q <= '0;
    end else begin
      if (GPR_in && write_ok) gpr[sel_idx] <= DATA;
      if (IR_in) ir_q <= DATA;
      // Address must stay stable while a RAM access is in flight.
      if (MAR_in && !r_en && !w_en) mar_q <= DATA;
    end
  end

  assign REG_OUT_1   = gpr[1];
  assign REG_OUT_2   = gpr[2];
  assign REG_OUT_3   = gpr[3];
  assign REG_OUT_4   = gpr[4];
  assign REG_OUT_5   = gpr[5];
  assign REG_OUT_6   = gpr[6];
  assign REG_OUT_7   = gpr[7];
  assign REG_OUT_IR  = ir_q;
  assign REG_OUT_MAR = mar_q;

  assign opcode_out = ir_q[15:12];
  assign rd_out_1   = ir_q[11:9];
  assign rd_out_2   = ir_q[8:6];
  assign S          = ir_q[8];
  assign shift      = ir_q[7:6];
  assign rs_1       = ir_q[5:3];
  assign rs_2       = ir_q[2:0];

endmodule

// File: tb/tb_gpr_ir_mar_datapath.sv
// Self-checking bench for gpr_ir_mar_datapath: directed cases plus random traffic
// against an array-based register model. Honours GPR_R0_ZERO_EN when defined.
module tb_gpr_ir_mar_datapath;

  logic        clk;
  logic        reset;
  wire  [15:0] DATA;
  logic [15:0] drv;
  logic        drv_en;
  logic        gpr_in, gpr_out, ir_in, mar_in, r_en, w_en;
  logic [2:0]  gpr_select;
  logic [15:0] ro [8];
  logic [15:0] reg_ir, reg_mar;
  logic [3:0]  opcode_out;
  logic [2:0]  rd_out_1, rd_out_2, rs_1, rs_2;
  logic        s_bit;
  logic [1:0]  shift;

  int total = 0;
  int bad   = 0;

  logic [15:0] model_gpr [8];
  logic [15:0] model_ir;
  logic [15:0] model_mar;

`ifdef GPR_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  assign DATA = drv_en ? drv : 'z;

  gpr_ir_mar_datapath #(.WIDTH(16), .NUM_REGS(8)) dut (
    .clk(clk), .reset(reset), .DATA(DATA),
    .GPR_in(gpr_in), .GPR_out(gpr_out), .GPR_select(gpr_select),
    .IR_in(ir_in), .MAR_in(mar_in), .r_en(r_en), .w_en(w_en),
    .REG_OUT_0(ro[0]), .REG_OUT_1(ro[1]), .REG_OUT_2(ro[2]), .REG_OUT_3(ro[3]),
    .REG_OUT_4(ro[4]), .REG_OUT_5(ro[5]), .REG_OUT_6(ro[6]), .REG_OUT_7(ro[7]),
    .REG_OUT_IR(reg_ir), .opcode_out(opcode_out), .rd_out_1(rd_out_1),
    .rd_out_2(rd_out_2), .S(s_bit), .shift(shift), .rs_1(rs_1), .rs_2(rs_2),
    .REG_OUT_MAR(reg_mar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int model_idx(input logic [2:0] sel);
    int f;
    f = int'(model_ir);
    case (sel)
      3'd0:    return (f / 512) % 8;
      3'd1:    return (f / 64) % 8;
      3'd2:    return (f / 8) % 8;
      3'd3:    return f % 8;
      3'd4:    return 7;
      3'd5:    return 6;
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] model_read(input int idx);
    if (R0_ZERO && idx == 0) return 16'h0000;
    return model_gpr[idx];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) model_gpr[i] = 16'h0000;
    model_ir  = 16'h0000;
    model_mar = 16'h0000;
  endtask

  task automatic check_all();
    int f;
    f = int'(model_ir);
    for (int i = 0; i < 8; i++) check($sformatf("reg%0d", i), ro[i], model_read(i));
    check("ir",     reg_ir,            model_ir);
    check("mar",    reg_mar,           model_mar);
    check("opcode", 16'(opcode_out),   16'(f / 4096));
    check("rd1",    16'(rd_out_1),     16'((f / 512) % 8));
    check("rd2",    16'(rd_out_2),     16'((f / 64) % 8));
    check("s",      16'(s_bit),        16'((f / 256) % 2));
    check("shift",  16'(shift),        16'((f / 64) % 4));
    check("rs1",    16'(rs_1),         16'((f / 8) % 8));
    check("rs2",    16'(rs_2),         16'(f % 8));
  endtask

  // One bus cycle: drive at negedge, check the bus mid-cycle, update model at posedge.
  task automatic step(input logic gi, input logic go, input logic [2:0] sel,
                      input logic ii, input logic mi, input logic re, input logic we,
                      input logic [15:0] bus);
    int          idx;
    logic [15:0] exp_bus;
    @(negedge clk);
    gpr_in = gi; gpr_out = go; gpr_select = sel;
    ir_in = ii; mar_in = mi; r_en = re; w_en = we;
    drv_en = !go; drv = bus;
    #1;
    idx     = model_idx(sel);
    exp_bus = go ? model_read(idx) : bus;
    check("bus", DATA, exp_bus);
    @(posedge clk);
    if (gi && !(R0_ZERO && idx == 0)) model_gpr[idx] = exp_bus;
    if (ii) model_ir = exp_bus;
    if (mi && !re && !we) model_mar = exp_bus;
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1; drv_en = 1'b1; drv = 16'h0000;
    gpr_in = 0; gpr_out = 0; gpr_select = 0; ir_in = 0; mar_in = 0; r_en = 0; w_en = 0;
    model_clear();
    #2;
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // IR field decode
    step(0, 0, 3'd0, 1, 0, 0, 0, 16'h1A5B);
    check("dec_opcode", 16'(opcode_out), 16'd1);
    check("dec_rd1",    16'(rd_out_1),   16'd5);
    check("dec_rd2",    16'(rd_out_2),   16'd1);
    check("dec_s",      16'(s_bit),      16'd0);
    check("dec_shift",  16'(shift),      16'd1);
    check("dec_rs1",    16'(rs_1),       16'd3);
    check("dec_rs2",    16'(rs_2),       16'd3);

    // Write through rd_1 = 2, read back onto the bus, then release the bus
    step(0, 0, 3'd0, 1, 0, 0, 0, 16'h0400);
    step(1, 0, 3'd0, 0, 0, 0, 0, 16'hBEEF);
    check("r2_beef", ro[2], 16'hBEEF);
    step(0, 1, 3'd0, 0, 0, 0, 0, 16'h0000);
    check("bus_beef", DATA, 16'hBEEF);
    step(0, 0, 3'd0, 0, 0, 0, 0, 16'h5555);
    check("bus_released", DATA, 16'h5555);

    // PC write, then simultaneous in/out leaves it unchanged
    step(1, 0, 3'd4, 0, 0, 0, 0, 16'h0040);
    check("r7_0040", ro[7], 16'h0040);
    step(1, 1, 3'd4, 0, 0, 0, 0, 16'h0000);
    check("r7_hold", ro[7], 16'h0040);

    // MAR load and hold during read/write access
    step(0, 0, 3'd0, 0, 1, 0, 0, 16'h00C3);
    check("mar_c3", reg_mar, 16'h00C3);
    step(0, 0, 3'd0, 0, 1, 1, 0, 16'h0011);
    check("mar_hold_r", reg_mar, 16'h00C3);
    step(0, 0, 3'd0, 0, 1, 0, 1, 16'h0022);
    check("mar_hold_w", reg_mar, 16'h00C3);

    // IR load and GPR write on the same edge use the old IR index (rd_1 = 2)
    step(1, 0, 3'd0, 1, 0, 0, 0, 16'h0A00);
    check("same_edge_r2", ro[2], 16'h0A00);

    // R0 write via select 110
    step(1, 0, 3'd6, 0, 0, 0, 0, 16'h1234);
    check("r0_write", ro[0], R0_ZERO ? 16'h0000 : 16'h1234);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
           $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 16'($urandom));
    end

    // Fill every register, IR and MAR with nonzero values, then reset mid-cycle
    for (int r = 0; r < 8; r++) begin
      step(0, 0, 3'd0, 1, 0, 0, 0, 16'(r * 512));
      step(1, 0, 3'd0, 0, 0, 0, 0, 16'(16'h1111 * (r + 1)));
    end
    step(0, 0, 3'd0, 1, 1, 0, 0, 16'hF7FF);
    @(negedge clk);
    gpr_in = 0; gpr_out = 0; ir_in = 0; mar_in = 0;
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;
    step(1, 0, 3'd5, 0, 0, 0, 0, 16'h7E57);
    check("r6_after_reset", ro[6], 16'h7E57);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
